// File: rtl/branch_predictor_btb_pkg.sv
// Shared definitions for the fetch-side branch predictor.
//   - 2-bit saturating counter encodings (strong/weak not-taken/taken)
//   - counter value written on allocation and on reset
//   - default BTB depth
// Imported by branch_predictor_btb and sat_ctr2.
package branch_predictor_btb_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weak taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strong taken

    // A freshly allocated entry was just seen taken, so it starts weak taken.
    localparam logic [1:0] CTR_INIT_ALLOC = CTR_WT;
    localparam logic [1:0] CTR_RESET      = CTR_WNT;

    localparam int BP_ENTRIES_DEFAULT = 64;

endpackage

// File: rtl/branch_predictor_btb_sat_ctr2.sv
// sat_ctr2: combinational next state of a 2-bit saturating counter.
// Ports:
//   ctr_i    in  2  current counter value
//   taken_i  in  1  resolved outcome (1 = count up, 0 = count down)
//   ctr_o    out 2  next counter value, saturating at CTR_ST / CTR_SNT
module sat_ctr2 import branch_predictor_btb_pkg::*; (
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped branch target buffer with 2-bit
// saturating counters, feeding the fetch stage and trained from execute.
//
// Lookup is purely combinational on pc; updates commit on the rising clk
// edge, so a lookup that races an update to the same index sees the old
// entry and the new one from the following cycle.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   pc          in  32        fetch PC to look up (bits [1:0] ignored)
//   hit         out 1         valid entry with matching tag
//   taken       out 1         counter MSB of the hit entry (0 on miss)
//   pred_PC     out 32        stored target of the hit entry (0 on miss)
//   upd_valid   in  1         resolved branch/jump this cycle
//   upd_pc      in  32        PC of the resolved instruction
//   upd_taken   in  1         actual outcome
//   upd_target  in  32        actual target (used when upd_taken)
//   upd_mispred in  1         mispredict flag, feeds statistics only
//
// Build option BP_STATS_EN: adds 32-bit wrapping counters stat_lookups,
// stat_hits, stat_upd and stat_mispred. Without it those ports do not
// exist and upd_mispred is ignored.
module branch_predictor_btb import branch_predictor_btb_pkg::*; #(
    parameter int ENTRIES = BP_ENTRIES_DEFAULT,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        hit,
    output logic        taken,
    output logic [31:0] pred_PC,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispred
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_upd,
    output logic [31:0] stat_mispred
`endif
);

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic               upd_hit;
    logic [1:0]         ctr_nxt;
    logic               tag_we, tgt_we, ctr_we;
    logic [TAG_W-1:0]   tag_d;
    logic [31:0]        target_d;
    logic [1:0]         ctr_d;

    assign lk_idx  = pc[IDX_W+1:2];
    assign lk_tag  = pc[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    // Lookup path: reads only registered state, so same-cycle updates are
    // invisible until the next cycle.
    always_comb begin
        hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        taken   = hit && ctr_q[lk_idx][1];
        pred_PC = hit ? target_q[lk_idx] : 32'h0;
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    sat_ctr2 u_sat_ctr2 (
        .ctr_i   (ctr_q[upd_idx]),
        .taken_i (upd_taken),
        .ctr_o   (ctr_nxt)
    );

    // Training: a hit trains the counter (and refreshes the target on a
    // taken outcome); a taken miss allocates or evicts; a not-taken miss
    // leaves the table alone so cold not-taken branches never pollute it.
    always_comb begin
        valid_d  = valid_q;
        tag_we   = 1'b0;
        tgt_we   = 1'b0;
        ctr_we   = 1'b0;
        tag_d    = upd_tag;
        target_d = upd_target;
        ctr_d    = ctr_nxt;
        if (upd_valid) begin
            if (upd_hit) begin
                ctr_we = 1'b1;
                tgt_we = upd_taken;
            end else if (upd_taken) begin
                valid_d[upd_idx] = 1'b1;
                tag_we           = 1'b1;
                tgt_we           = 1'b1;
                ctr_we           = 1'b1;
                ctr_d            = CTR_INIT_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
        end else if (ctr_we) begin
            ctr_q[upd_idx] <= ctr_d;
        end
    end

    // Tag/target need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (tag_we) tag_q[upd_idx]    <= tag_d;
        if (tgt_we) target_q[upd_idx] <= target_d;
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_hits_q,    stat_hits_d;
    logic [31:0] stat_upd_q,     stat_upd_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_lookups_d = stat_lookups_q + 32'd1;
        stat_hits_d    = stat_hits_q    + {31'd0, hit};
        stat_upd_d     = stat_upd_q     + {31'd0, upd_valid};
        stat_mispred_d = stat_mispred_q + {31'd0, upd_valid & upd_mispred};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_lookups_q <= '0;
            stat_hits_q    <= '0;
            stat_upd_q     <= '0;
            stat_mispred_q <= '0;
        end else begin
            stat_lookups_q <= stat_lookups_d;
            stat_hits_q    <= stat_hits_d;
            stat_upd_q     <= stat_upd_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    assign stat_lookups = stat_lookups_q;
    assign stat_hits    = stat_hits_q;
    assign stat_upd     = stat_upd_q;
    assign stat_mispred = stat_mispred_q;

    logic unused_bits;
    assign unused_bits = ^{pc[1:0], upd_pc[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{pc[1:0], upd_pc[1:0], upd_mispred};
`endif

endmodule
